// File: rtl/vdp_vram_arbiter.sv
// vdp_vram_arbiter: schedules the single-port VDP VRAM between the
// background fetcher, the sprite fetcher and the CPU data port.
module vdp_vram_arbiter #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bg_active,
  input  logic        bg_free,
  input  logic [13:0] bg_addr,
  input  logic        spr_req,
  input  logic [13:0] spr_addr,
  output logic        spr_ack,
  output logic        spr_valid,
  output logic [7:0]  spr_data,
  input  logic        cpu_addr_load,
  input  logic [13:0] cpu_addr_in,
  input  logic        cpu_prefetch,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_wr_data,
  input  logic        cpu_rd,
  output logic [7:0]  cpu_rd_data,
  output logic        cpu_busy,
  output logic [13:0] vram_addr,
  output logic        vram_we,
  output logic [7:0]  vram_wdata,
  input  logic [7:0]  vram_rdata
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE,
    WR_PEND,
    RD_PEND,
    RD_WAIT
  } cpu_state_t;

  cpu_state_t    state;
  logic [13:0]   cpu_addr;
  logic [7:0]    rbuf;
  logic [7:0]    wdata_reg;
  logic [SW-1:0] starve_cnt;

  logic bg_own;
  logic cpu_pend;
  logic starved;
  logic cpu_gnt;
  logic spr_gnt;

  assign bg_own   = bg_active & ~bg_free;
  assign cpu_pend = (state == WR_PEND) | (state == RD_PEND);
  assign starved  = starve_cnt >= SW'(STARVE_LIMIT);

  // A starved CPU op jumps ahead of the sprite unit, never ahead of BG.
  assign cpu_gnt = ~bg_own & cpu_pend & (starved | ~spr_req);
  assign spr_gnt = ~rst & ~bg_own & spr_req & ~(cpu_pend & starved);

  assign spr_ack     = spr_gnt;
  assign spr_data    = vram_rdata;
  assign cpu_rd_data = rbuf;
  assign cpu_busy    = (state != IDLE);
  assign vram_we     = cpu_gnt & (state == WR_PEND);
  assign vram_wdata  = wdata_reg;

  always_comb begin
    vram_addr = bg_addr;
    if (cpu_gnt) begin
      vram_addr = cpu_addr;
    end else if (spr_gnt) begin
      vram_addr = spr_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cpu_addr  <= '0;
      rbuf      <= '0;
      wdata_reg <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cpu_addr_load) begin
            cpu_addr <= cpu_addr_in;
            if (cpu_prefetch) begin
              state <= RD_PEND;
            end
          end else if (cpu_wr) begin
            wdata_reg <= cpu_wr_data;
            state     <= WR_PEND;
          end else if (cpu_rd) begin
            state <= RD_PEND;
          end
        end
        WR_PEND: begin
          if (cpu_gnt) begin
            rbuf     <= wdata_reg;
            cpu_addr <= cpu_addr + 14'd1;
            state    <= IDLE;
          end
        end
        RD_PEND: begin
          if (cpu_gnt) begin
            state <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          rbuf     <= vram_rdata;
          cpu_addr <= cpu_addr + 14'd1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
      spr_valid  <= 1'b0;
    end else begin
      spr_valid <= spr_gnt;
      if (!cpu_pend || cpu_gnt) begin
        starve_cnt <= '0;
      end else if (spr_gnt && !starved) begin
        starve_cnt <= starve_cnt + SW'(1);
      end
    end
  end

endmodule

// File: tb/tb_vdp_vram_arbiter.sv
// tb_vdp_vram_arbiter: directed and randomized checks of the VRAM
// arbiter against a byte-level model of the CPU data port and RAM.
module tb_vdp_vram_arbiter;

  localparam int LIMIT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        bg_active, bg_free;
  logic [13:0] bg_addr;
  logic        spr_req;
  logic [13:0] spr_addr;
  logic        spr_ack, spr_valid;
  logic [7:0]  spr_data;
  logic        cpu_addr_load;
  logic [13:0] cpu_addr_in;
  logic        cpu_prefetch, cpu_wr;
  logic [7:0]  cpu_wr_data;
  logic        cpu_rd;
  logic [7:0]  cpu_rd_data;
  logic        cpu_busy;
  logic [13:0] vram_addr;
  logic        vram_we;
  logic [7:0]  vram_wdata;
  logic [7:0]  vram_rdata;

  always #5 clk = ~clk;

  vdp_vram_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .bg_active(bg_active), .bg_free(bg_free), .bg_addr(bg_addr),
    .spr_req(spr_req), .spr_addr(spr_addr),
    .spr_ack(spr_ack), .spr_valid(spr_valid), .spr_data(spr_data),
    .cpu_addr_load(cpu_addr_load), .cpu_addr_in(cpu_addr_in),
    .cpu_prefetch(cpu_prefetch), .cpu_wr(cpu_wr),
    .cpu_wr_data(cpu_wr_data), .cpu_rd(cpu_rd),
    .cpu_rd_data(cpu_rd_data), .cpu_busy(cpu_busy),
    .vram_addr(vram_addr), .vram_we(vram_we),
    .vram_wdata(vram_wdata), .vram_rdata(vram_rdata)
  );

  function automatic logic [7:0] init_val(int i);
    return 8'((i * 37 + 11) ^ (i >> 8));
  endfunction

  // Synchronous single-port RAM environment
  logic [7:0]  ram [0:16383];
  logic        ram_init = 1'b0;
  logic        pl_en = 1'b0;
  logic [13:0] pl_addr = '0;
  logic [7:0]  pl_data = '0;

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 16384; i++) ram[i] <= init_val(i);
    end else begin
      if (pl_en) ram[pl_addr] <= pl_data;
      if (vram_we) ram[vram_addr] <= vram_wdata;
    end
    vram_rdata <= ram[vram_addr];
  end

  // Reference model state
  logic [7:0]  ref_mem [0:16383];
  logic [13:0] m_addr;
  logic [7:0]  m_buf;

  int tests = 0;
  int fails = 0;
  int we_cnt = 0;
  int ack_cnt = 0;
  int phase = 0;
  int last_we_phase = -1;
  logic [13:0] last_waddr = '0;
  logic [7:0]  last_wdata = '0;
  logic        prev_ack = 1'b0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    logic a;
    #1;
    if (bg_active && !bg_free)
      check("bg_slot", {16'b0, vram_we, spr_ack, vram_addr},
            {16'b0, 1'b0, 1'b0, bg_addr});
    check("spr_valid", 32'(spr_valid), 32'(prev_ack));
    if (spr_ack) check("spr_addr", 32'(vram_addr), 32'(spr_addr));
    a = spr_ack;
    if (a) ack_cnt++;
    if (vram_we) begin
      we_cnt++;
      last_waddr = vram_addr;
      last_wdata = vram_wdata;
      last_we_phase = phase;
    end
    @(posedge clk);
    @(negedge clk);
    prev_ack = a;
  endtask

  task automatic rand_env();
    bg_active = 1'($urandom % 2);
    bg_free   = ($urandom % 3) == 0;
    bg_addr   = 14'($urandom);
    spr_req   = 1'($urandom % 2);
    spr_addr  = 14'($urandom);
  endtask

  task automatic quiet_env();
    bg_active = 1'b0;
    bg_free   = 1'b0;
    spr_req   = 1'b0;
  endtask

  // kind: 0 = address load, 1 = write, 2 = read
  task automatic run_op(int kind, logic [13:0] a, logic pf,
                        logic [7:0] d, logic rnd, string tag);
    int we0, n, pre, ac;
    we0 = we_cnt;
    pre = 0;
    n = 0;
    if (rnd) rand_env();
    if (kind == 2) check({tag, "_rdbuf"}, 32'(cpu_rd_data), 32'(m_buf));
    cpu_addr_load = (kind == 0);
    cpu_addr_in   = a;
    cpu_prefetch  = pf;
    cpu_wr        = (kind == 1);
    cpu_wr_data   = d;
    cpu_rd        = (kind == 2);
    cyc();
    cpu_addr_load = 1'b0;
    cpu_prefetch  = 1'b0;
    cpu_wr        = 1'b0;
    cpu_rd        = 1'b0;
    while (cpu_busy && n < 200) begin
      if (rnd) rand_env();
      ac = ack_cnt;
      cyc();
      if (we_cnt == we0) pre += ack_cnt - ac;
      n++;
    end
    check({tag, "_done"}, 32'(n < 200), 32'd1);
    if (kind == 1) begin
      check({tag, "_wcnt"}, 32'(we_cnt - we0), 32'd1);
      check({tag, "_waddr"}, 32'(last_waddr), 32'(m_addr));
      check({tag, "_wdata"}, 32'(last_wdata), 32'(d));
      check({tag, "_starve"}, 32'(pre <= LIMIT), 32'd1);
      ref_mem[m_addr] = d;
      m_buf = d;
      m_addr = m_addr + 14'd1;
    end else begin
      check({tag, "_nowr"}, 32'(we_cnt - we0), 32'd0);
      if (kind == 0) m_addr = a;
      if (kind == 2 || pf) begin
        m_buf = ref_mem[m_addr];
        m_addr = m_addr + 14'd1;
      end
    end
    check({tag, "_buf"}, 32'(cpu_rd_data), 32'(m_buf));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int we0, exp_i, mism;
    logic [13:0] a;
    for (int i = 0; i < 16384; i++) ref_mem[i] = init_val(i);
    rst = 1'b1;
    bg_active = 1'b0; bg_free = 1'b0; bg_addr = 14'h0123;
    spr_req = 1'b1; spr_addr = 14'h0456;
    cpu_addr_load = 1'b0; cpu_addr_in = '0; cpu_prefetch = 1'b0;
    cpu_wr = 1'b0; cpu_wr_data = '0; cpu_rd = 1'b0;
    ram_init = 1'b1;
    #1;
    check("rst_busy", 32'(cpu_busy), 32'd0);
    check("rst_we", 32'(vram_we), 32'd0);
    check("rst_ack", 32'(spr_ack), 32'd0);
    check("rst_valid", 32'(spr_valid), 32'd0);
    check("rst_rdbuf", 32'(cpu_rd_data), 32'd0);
    @(negedge clk);
    cyc();
    ram_init = 1'b0;
    spr_req = 1'b0;
    cyc();
    rst = 1'b0;
    m_addr = '0;
    m_buf = '0;
    cyc();

    // Load 0x3FFF without prefetch, then write with exact timing
    cpu_addr_load = 1'b1; cpu_addr_in = 14'h3FFF;
    cyc();
    cpu_addr_load = 1'b0;
    #1;
    check("load_nopf_busy", 32'(cpu_busy), 32'd0);
    cpu_wr = 1'b1; cpu_wr_data = 8'hA5;
    cyc();
    cpu_wr = 1'b0;
    #1;
    check("wr_t1_busy", 32'(cpu_busy), 32'd1);
    check("wr_t1_we", 32'(vram_we), 32'd1);
    check("wr_t1_addr", 32'(vram_addr), 32'h3FFF);
    check("wr_t1_wdata", 32'(vram_wdata), 32'hA5);
    cyc();
    #1;
    check("wr_t2_busy", 32'(cpu_busy), 32'd0);
    check("wr_t2_we", 32'(vram_we), 32'd0);
    check("wr_t2_buf", 32'(cpu_rd_data), 32'hA5);
    ref_mem[14'h3FFF] = 8'hA5;
    m_addr = 14'h0000;
    m_buf = 8'hA5;
    run_op(1, '0, 1'b0, 8'h5A, 1'b0, "wrap_wr");

    // Read-ahead timing
    pl_en = 1'b1; pl_addr = 14'h0100; pl_data = 8'h11;
    cyc();
    pl_addr = 14'h0101; pl_data = 8'h22;
    cyc();
    pl_en = 1'b0;
    ref_mem[14'h0100] = 8'h11;
    ref_mem[14'h0101] = 8'h22;
    cpu_addr_load = 1'b1; cpu_addr_in = 14'h0100; cpu_prefetch = 1'b1;
    cyc();
    cpu_addr_load = 1'b0; cpu_prefetch = 1'b0;
    #1;
    check("pf_t1_busy", 32'(cpu_busy), 32'd1);
    check("pf_t1_addr", 32'(vram_addr), 32'h0100);
    check("pf_t1_we", 32'(vram_we), 32'd0);
    cyc();
    #1;
    check("pf_t2_busy", 32'(cpu_busy), 32'd1);
    cyc();
    #1;
    check("pf_t3_busy", 32'(cpu_busy), 32'd0);
    check("pf_t3_buf", 32'(cpu_rd_data), 32'h11);
    check("rd_strobe_buf", 32'(cpu_rd_data), 32'h11);
    cpu_rd = 1'b1;
    cyc();
    cpu_rd = 1'b0;
    #1;
    check("rd_t1_addr", 32'(vram_addr), 32'h0101);
    check("rd_t1_busy", 32'(cpu_busy), 32'd1);
    cyc();
    cyc();
    #1;
    check("rd_t3_busy", 32'(cpu_busy), 32'd0);
    check("rd_t3_buf", 32'(cpu_rd_data), 32'h22);
    m_addr = 14'h0102;
    m_buf = 8'h22;
    run_op(1, '0, 1'b0, 8'h33, 1'b0, "after_rd_wr");

    // Active display: write only in a bg_free slot
    we0 = we_cnt;
    exp_i = -1;
    for (int i = 0; i < 16; i++) begin
      phase = i;
      bg_active = 1'b1;
      bg_free = (i % 8 == 2) || (i % 8 == 7);
      bg_addr = 14'($urandom);
      if (exp_i < 0 && i > 3 && bg_free) exp_i = i;
      cpu_wr = (i == 3);
      cpu_wr_data = 8'hC3;
      cyc();
    end
    cpu_wr = 1'b0;
    quiet_env();
    phase = 0;
    check("bg_wcnt", 32'(we_cnt - we0), 32'd1);
    check("bg_wslot", 32'(last_we_phase), 32'(exp_i));
    check("bg_waddr", 32'(last_waddr), 32'(m_addr));
    ref_mem[m_addr] = 8'hC3;
    m_buf = 8'hC3;
    m_addr = m_addr + 14'd1;

    // Sprite starvation bound
    spr_req = 1'b1;
    spr_addr = 14'h2AAA;
    cpu_wr = 1'b1;
    cpu_wr_data = 8'h3C;
    cyc();
    cpu_wr = 1'b0;
    for (int i = 1; i <= LIMIT + 2; i++) begin
      #1;
      check("starve_ack", 32'(spr_ack), 32'(i != LIMIT + 1));
      check("starve_we", 32'(vram_we), 32'(i == LIMIT + 1));
      cyc();
    end
    spr_req = 1'b0;
    cyc();
    check("starve_waddr", 32'(last_waddr), 32'(m_addr));
    ref_mem[m_addr] = 8'h3C;
    m_buf = 8'h3C;
    m_addr = m_addr + 14'd1;

    // Simultaneous strobes and strobes while busy
    we0 = we_cnt;
    cpu_wr = 1'b1; cpu_rd = 1'b1; cpu_wr_data = 8'h77;
    cyc();
    cpu_wr_data = 8'h99;
    cpu_addr_load = 1'b1; cpu_addr_in = 14'h1234;
    cyc();
    cpu_wr = 1'b0; cpu_rd = 1'b0; cpu_addr_load = 1'b0;
    cyc();
    cyc();
    check("dual_wcnt", 32'(we_cnt - we0), 32'd1);
    check("dual_wdata", 32'(last_wdata), 32'h77);
    check("dual_waddr", 32'(last_waddr), 32'(m_addr));
    check("dual_busy", 32'(cpu_busy), 32'd0);
    check("dual_buf", 32'(cpu_rd_data), 32'h77);
    ref_mem[m_addr] = 8'h77;
    m_buf = 8'h77;
    m_addr = m_addr + 14'd1;
    we0 = we_cnt;
    a = 14'($urandom);
    cpu_addr_load = 1'b1; cpu_addr_in = a; cpu_prefetch = 1'b1;
    cyc();
    cpu_addr_load = 1'b0; cpu_prefetch = 1'b0;
    cpu_wr = 1'b1; cpu_wr_data = 8'hEE;
    cyc();
    cyc();
    cpu_wr = 1'b0;
    cyc();
    check("busyrd_nowr", 32'(we_cnt - we0), 32'd0);
    check("busyrd_buf", 32'(cpu_rd_data), 32'(ref_mem[a]));
    m_buf = ref_mem[a];
    m_addr = a + 14'd1;

    // Reset during RD_WAIT
    cpu_addr_load = 1'b1; cpu_addr_in = 14'h0100; cpu_prefetch = 1'b1;
    cyc();
    cpu_addr_load = 1'b0; cpu_prefetch = 1'b0;
    cyc();
    rst = 1'b1;
    #1;
    check("rstmid_busy", 32'(cpu_busy), 32'd0);
    check("rstmid_we", 32'(vram_we), 32'd0);
    check("rstmid_buf", 32'(cpu_rd_data), 32'd0);
    prev_ack = 1'b0;
    cyc();
    rst = 1'b0;
    m_addr = '0;
    m_buf = '0;
    cyc();
    run_op(1, '0, 1'b0, 8'h44, 1'b0, "post_rst_wr");

    // Randomized traffic against the model
    for (int k = 0; k < 60; k++) begin
      run_op(int'($urandom % 3), 14'($urandom), 1'($urandom % 2),
             8'($urandom), 1'b1, "rnd");
    end
    quiet_env();
    cyc();
    cyc();
    mism = 0;
    for (int i = 0; i < 16384; i++) begin
      if (ram[i] !== ref_mem[i]) mism++;
    end
    check("ram_image", 32'(mism), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vdp_vram_arbiter.md
# vdp_vram_arbiter

Schedules every access to the single-port 16 KB VDP VRAM between three requesters: the background tile fetcher, the sprite fetcher and the CPU data port. It sits between those units and the VRAM macro. The background fetcher owns the RAM on its fixed slots. Sprite and CPU traffic fill the remaining cycles. The CPU side implements the VDP data-port semantics: auto-incrementing address, read-ahead buffer, and writes that refresh the buffer.

## Interface
- STARVE_LIMIT, 8: consecutive cycles a pending CPU op may lose to the sprite unit before CPU takes priority over sprite
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-high reset
- bg_active  in  1  background fetcher is in its fetch window (active display)
- bg_free  in  1  background does not need VRAM this cycle (its tile slots 2 and 7)
- bg_addr  in  14  background address, passed through combinationally
- spr_req  in  1  level; held until acked
- spr_addr  in  14  sprite fetch address, stable while spr_req high
- spr_ack  out  1  pulse: sprite access issued this cycle
- spr_valid  out  1  pulse one cycle after spr_ack; spr_data valid
- spr_data  out  8  = vram_rdata
- cpu_addr_load  in  1  strobe: load cpu_addr_in
- cpu_addr_in  in  14  new CPU address
- cpu_prefetch  in  1  qualifies cpu_addr_load: also schedule a read-ahead (code 0)
- cpu_wr  in  1  strobe: write cpu_wr_data
- cpu_wr_data  in  8  write data
- cpu_rd  in  1  strobe: consume read buffer, schedule next read-ahead
- cpu_rd_data  out  8  read buffer contents (registered)
- cpu_busy  out  1  CPU op pending; CPU strobes ignored while high
- vram_addr  out  14  RAM address (combinational mux)
- vram_we  out  1  RAM write enable
- vram_wdata  out  8  RAM write data
- vram_rdata  in  8  RAM read data, valid one cycle after address (synchronous RAM)

## Operation
- Owner each cycle, combinational, in priority order:
  - BG if bg_active && !bg_free;
  - else CPU if pending and starve_cnt ≥ STARVE_LIMIT;
  - else SPR if spr_req;
  - else CPU if pending;
  - else BG (idle; vram_addr = bg_addr, we=0).
- Outside bg_active, bg_free is don't-care: all cycles go to SPR/CPU.
- CPU FSM states: IDLE, WR_PEND, RD_PEND, RD_WAIT.
  - IDLE + cpu_addr_load: cpu_addr←cpu_addr_in. If cpu_prefetch, go to RD_PEND, else stay IDLE.
  - IDLE + cpu_wr: wdata_reg←cpu_wr_data, go to WR_PEND.
  - IDLE + cpu_rd: go to RD_PEND. cpu_rd_data already holds the returned byte; the CPU samples it in the strobe cycle.
  - WR_PEND granted: vram_we=1, vram_addr=cpu_addr, vram_wdata=wdata_reg. At the edge: read buffer←wdata_reg, cpu_addr++, go to IDLE.
  - RD_PEND granted: vram_addr=cpu_addr, go to RD_WAIT.
  - RD_WAIT: read buffer←vram_rdata, cpu_addr++, go to IDLE.
- Simultaneous strobes in IDLE: cpu_addr_load wins; cpu_wr beats cpu_rd; the losers are dropped.
- cpu_busy = (state ≠ IDLE).
- cpu_addr is 14 bits and wraps 0x3FFF→0x0000.
- starve_cnt:
  - increments each cycle the CPU is pending and SPR is granted;
  - clears when CPU is granted or IDLE;
  - saturates at STARVE_LIMIT.
- Sprite: spr_ack=1 in the grant cycle; spr_valid=1 the next cycle. spr_req held across a BG-owned cycle simply waits.
- Reset values: cpu_addr 0, read buffer 0, wdata_reg 0, state IDLE, starve_cnt 0, spr_ack 0, spr_valid 0, cpu_busy 0, vram_we 0.
- Reset mid-op drops the pending op; no write is issued after rst asserts.

## Timing
- Strobe sampled at edge ending cycle T; busy high from T+1.
- Write, uncontended: granted T+1 (we=1), busy low T+2.
- Read-ahead, uncontended: address at T+1, data captured at edge ending T+2, cpu_rd_data updated and busy low T+3.
- Worst case in active display: a CPU op waits for the next bg_free slot; STARVE_LIMIT bounds loss to sprites.
- vram_addr/vram_we are combinational from registered state plus bg_active/bg_free/bg_addr/spr_req. There is no added latency on the background path.

## Test plan
- Reset, then cpu_addr_load 0x3FFF (no prefetch), cpu_wr 0xA5 outside active → vram_we at 0x3FFF for one cycle, cpu_addr→0x0000, cpu_rd_data=0xA5.
- Preload RAM[0x0100]=0x11, RAM[0x0101]=0x22. Load 0x0100 with prefetch; cpu_rd → busy 2 cycles, then cpu_rd_data=0x11. Next cpu_rd returns 0x11 and prefetches 0x22; cpu_addr=0x0102.
- bg_active=1, bg_free asserted 2 of every 8 cycles, CPU write pending → write issued only in a bg_free cycle; vram_addr equals bg_addr in every other cycle.
- spr_req held continuously with a CPU write pending and bg_active=0 → sprite granted 8 cycles, CPU granted on cycle 9, then sprite resumes. spr_valid follows each spr_ack by exactly 1 cycle.
- cpu_wr and cpu_rd in the same cycle, and cpu_wr while busy → only the write is executed; strobes arriving while busy cause no RAM access.
- rst asserted in RD_WAIT → busy and vram_we low immediately, cpu_rd_data=0, cpu_addr=0.
